// File: rtl/ad_sample_sdram_addr_gen_if.sv
// Sample-in / word-out bus for ad_sample_sdram_addr_gen.
// master: ADC source and SDRAM writer side; slave: the address generator.
interface ad_sample_sdram_addr_gen_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        dev_idle;
    logic        write_en;
    logic [15:0] data;
    logic [31:0] addr;

    modport master (
        output s_valid, s_data, dev_idle,
        input  write_en, data, addr
    );

    modport slave (
        input  s_valid, s_data, dev_idle,
        output write_en, data, addr
    );
endinterface

// File: rtl/ad_sample_sdram_addr_gen.sv
// ADC sample -> SDRAM address generator with a small holding FIFO and
// burst-aligned flush on stop. Ring or one-shot capture region.
// Optional macro ADC_TEST_PATTERN_EN adds a test_mode input that replaces
// sample data with a per-capture word counter.
module ad_sample_sdram_addr_gen #(
    parameter int unsigned HOLD_DEPTH = 4,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned ADDR_STEP  = 2,
    parameter logic [15:0] PAD_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_base_addr,
    input  logic [23:0] cfg_len_words,
    input  logic        cfg_oneshot,
    input  logic        start,
    input  logic        stop,
`ifdef ADC_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    ad_sample_sdram_addr_gen_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic [23:0] wr_offset,
    output logic [15:0] wrap_cnt,
    output logic [15:0] ovf_cnt
);
    localparam int unsigned PW = $clog2(HOLD_DEPTH);
    localparam logic [23:0] BURST = 24'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state;

    logic [31:0] base_r;
    logic [23:0] len_r;
    logic        oneshot_r;
    logic [15:0] pat_cnt;

    logic [15:0] mem_data [HOLD_DEPTH];
    logic [31:0] mem_addr [HOLD_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_next;

    logic        empty, full, pop, room, oneshot_hold;
    logic        accept, drop, pad, push;
    logic [15:0] push_data;
    logic [31:0] push_addr;
    logic [23:0] start_len, off_inc, off_next;
    logic        wrap_now;
    logic        test_sel;

`ifdef ADC_TEST_PATTERN_EN
    assign test_sel = test_mode;
`else
    assign test_sel = 1'b0;
`endif

    assign start_len = cfg_len_words - (cfg_len_words % BURST);
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);

    // Datapath decisions for this cycle: output handshake, push source, next offset.
    always_comb begin
        empty        = (count == '0);
        full         = (count == (PW+1)'(HOLD_DEPTH));
        bus.write_en = !empty && bus.dev_idle;
        bus.data     = empty ? '0 : mem_data[rd_ptr];
        bus.addr     = empty ? '0 : mem_addr[rd_ptr];
        pop          = bus.write_en;
        room         = !full || pop;
        oneshot_hold = oneshot_r && (wr_offset == len_r);
        accept       = (state == RUN) && bus.s_valid && room && !oneshot_hold;
        drop         = (state == RUN) && bus.s_valid && !room && !oneshot_hold;
        pad          = (state == FLUSH) && room && ((wr_offset % BURST) != '0);
        push         = accept || pad;
        push_data    = pad ? PAD_WORD : (test_sel ? pat_cnt : bus.s_data);
        push_addr    = base_r + {8'd0, wr_offset} * 32'(ADDR_STEP);
        off_inc      = wr_offset + 24'd1;
        wrap_now     = 1'b0;
        off_next     = wr_offset;
        if (push) begin
            if (off_inc == len_r && !oneshot_r) begin
                off_next = '0;
                wrap_now = 1'b1;
            end else begin
                off_next = off_inc;
            end
        end
        count_next = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    // Holding FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Holding FIFO storage; contents are masked at the output when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_addr[wr_ptr] <= push_addr;
        end
    end

    // Capture FSM, latched configuration and status counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            base_r    <= '0;
            len_r     <= '0;
            oneshot_r <= 1'b0;
            pat_cnt   <= '0;
            wr_offset <= '0;
            wrap_cnt  <= '0;
            ovf_cnt   <= '0;
        end else begin
            if (push) wr_offset <= off_next;
            if (wrap_now && wrap_cnt != '1) wrap_cnt <= wrap_cnt + 16'd1;
            if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
            if (accept) pat_cnt <= pat_cnt + 16'd1;
            case (state)
                IDLE, DONE: begin
                    if (start && start_len >= BURST) begin
                        state     <= RUN;
                        base_r    <= cfg_base_addr;
                        len_r     <= start_len;
                        oneshot_r <= cfg_oneshot;
                        pat_cnt   <= '0;
                        wr_offset <= '0;
                        wrap_cnt  <= '0;
                        ovf_cnt   <= '0;
                    end
                end
                RUN: begin
                    // Stop always goes through FLUSH: with an aligned offset FLUSH
                    // pushes no padding and only drains, which is the drain case.
                    if (stop)
                        state <= FLUSH;
                    else if (oneshot_r && off_next == len_r && count_next == '0)
                        state <= DONE;
                end
                FLUSH: begin
                    if ((off_next % BURST) == '0 && count_next == '0)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad_sample_sdram_addr_gen.sv
// Scoreboard bench for ad_sample_sdram_addr_gen: stimulus pushes expected
// {data, addr} words, a monitor pops and compares on every write_en.
module tb_ad_sample_sdram_addr_gen;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [23:0] cfg_len_words = '0;
    logic        cfg_oneshot = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, done;
    logic [23:0] wr_offset;
    logic [15:0] wrap_cnt, ovf_cnt;
`ifdef ADC_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [47:0] exp_q[$];

    localparam logic [31:0] BASE = 32'h0010_0000;

    ad_sample_sdram_addr_gen_if bus();

    ad_sample_sdram_addr_gen #(
        .HOLD_DEPTH(4),
        .BURST_LEN(16),
        .ADDR_STEP(2),
        .PAD_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cfg_base_addr(cfg_base_addr),
        .cfg_len_words(cfg_len_words),
        .cfg_oneshot(cfg_oneshot),
        .start(start),
        .stop(stop),
`ifdef ADC_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .bus(bus),
        .busy(busy),
        .done(done),
        .wr_offset(wr_offset),
        .wrap_cnt(wrap_cnt),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every word handed to the writer must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && bus.write_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got data=%h addr=%h expected no write", bus.data, bus.addr);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({bus.data, bus.addr} !== e) begin
                    bad++;
                    $display("FAIL write_word: got data=%h addr=%h expected data=%h addr=%h",
                             bus.data, bus.addr, e[47:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit expect_push, input logic [23:0] off);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        if (expect_push) exp_q.push_back({d, BASE + 32'(off) * 32'd2});
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_start(input logic [23:0] len, input logic oneshot);
        cfg_base_addr = BASE;
        cfg_len_words = len;
        cfg_oneshot   = oneshot;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop(input int unsigned from_off);
        for (int unsigned o = from_off; o < 16; o++)
            exp_q.push_back({16'h0000, BASE + 32'(o) * 32'd2});
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.dev_idle = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_write_en", {31'd0, bus.write_en}, 32'd0);
        check("rst_offset", {8'd0, wr_offset}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Continuous ring, len 32: 16 samples, then wrap at sample 33.
        do_start(24'd32, 1'b0);
        check("run_busy", {31'd0, busy}, 32'd1);
        send(16'h1000, 1'b1, 24'd0);
        check("latency_we", {31'd0, bus.write_en}, 32'd1);
        check("latency_data", {16'd0, bus.data}, 32'h0000_1000);
        check("latency_addr", bus.addr, 32'h0010_0000);
        for (int unsigned i = 1; i < 16; i++)
            send(16'h1000 + 16'(i), 1'b1, 24'(i));
        check("ring_off16", {8'd0, wr_offset}, 32'd16);
        for (int unsigned i = 16; i < 40; i++)
            send(16'h1000 + 16'(i), 1'b1, 24'(i % 32));
        check("ring_wrap_cnt", {16'd0, wrap_cnt}, 32'd1);
        check("ring_off8", {8'd0, wr_offset}, 32'd8);
        wait_drain("ring_drain");
        do_stop(8);
        wait_done("ring_done");
        check("ring_final_off", {8'd0, wr_offset}, 32'd16);
        wait_drain("ring_pad_drain");

        // 11 samples then stop: five pad words at offsets 11..15.
        do_start(24'd32, 1'b0);
        check("s11_off_clear", {8'd0, wr_offset}, 32'd0);
        check("s11_wrap_clear", {16'd0, wrap_cnt}, 32'd0);
        for (int unsigned i = 0; i < 11; i++)
            send(16'h2000 + 16'(i), 1'b1, 24'(i));
        do_stop(11);
        wait_done("s11_done");
        check("s11_off", {8'd0, wr_offset}, 32'd16);
        wait_drain("s11_drain");

        // One-shot, len 20 rounds to 16: samples past the region are ignored.
        do_start(24'd20, 1'b1);
        for (int unsigned i = 0; i < 20; i++)
            send(16'h3000 + 16'(i), i < 16, 24'(i));
        wait_done("os_done");
        wait_drain("os_drain");
        check("os_ovf", {16'd0, ovf_cnt}, 32'd0);
        check("os_off", {8'd0, wr_offset}, 32'd16);

        // Back-pressure: 6 samples into a 4-deep FIFO, 2 dropped.
        do_start(24'd32, 1'b0);
        bus.dev_idle = 1'b0;
        for (int unsigned i = 0; i < 6; i++)
            send(16'h4000 + 16'(i), i < 4, 24'(i));
        check("ovf_cnt", {16'd0, ovf_cnt}, 32'd2);
        check("ovf_off", {8'd0, wr_offset}, 32'd4);
        check("ovf_we_held", {31'd0, bus.write_en}, 32'd0);
        bus.dev_idle = 1'b1;
        wait_drain("ovf_drain");
        do_stop(4);
        wait_done("ovf_done");
        wait_drain("ovf_pad_drain");

        // Start with rounded length below one burst is ignored.
        do_start(24'd15, 1'b0);
        check("short_busy", {31'd0, busy}, 32'd0);
        check("short_done", {31'd0, done}, 32'd1);

        // Reset mid-run with three words held: all discarded, no flush.
        do_start(24'd32, 1'b0);
        bus.dev_idle = 1'b0;
        for (int unsigned i = 0; i < 3; i++)
            send(16'h5000 + 16'(i), 1'b0, 24'(i));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.dev_idle = 1'b1;
        #1;
        check("mrst_we", {31'd0, bus.write_en}, 32'd0);
        check("mrst_data", {16'd0, bus.data}, 32'd0);
        check("mrst_addr", bus.addr, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_off", {8'd0, wr_offset}, 32'd0);
        check("mrst_wrap", {16'd0, wrap_cnt}, 32'd0);
        check("mrst_ovf", {16'd0, ovf_cnt}, 32'd0);
        tick();
        tick();
        check("mrst_still_idle", {31'd0, busy | done | bus.write_en}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ad_sample_sdram_addr_gen.md
Name: ad_sample_sdram_addr_gen

Overview:
- Stage directly upstream of the SDRAM burst write FIFO. Takes the 16-bit ADC sample stream, assigns each word an SDRAM byte address inside a configurable ring or one-shot capture region, and hands {data, addr} pairs to the writer via write_en/data/addr.
- Respects the writer's dev_idle back-pressure through a small holding FIFO.
- On stop, pads the stream to a whole burst, because the writer only issues full 16-word bursts.

Parameters:
- HOLD_DEPTH, 4, holding FIFO depth in entries (power of 2, ≥2).
- BURST_LEN, 16, writer burst length in words; capture length and flush alignment unit.
- ADDR_STEP, 2, byte-address increment per 16-bit word.
- PAD_WORD, 16'h0000, data value used for flush padding.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- cfg_base_addr, in, 32, region start byte address; latched on start.
- cfg_len_words, in, 24, region length in words; latched on start and rounded down to a multiple of BURST_LEN.
- cfg_oneshot, in, 1, 1 = stop after the region is filled once; 0 = continuous ring. Latched on start.
- start, in, 1, single-cycle capture start pulse.
- stop, in, 1, single-cycle capture stop pulse.
- s_valid, in, 1, sample strobe; the ADC side has no back-pressure.
- s_data, in, 16, sample value.
- dev_idle, in, 1, writer can accept a word this cycle.
- write_en, out, 1, word handed to writer this cycle.
- data, out, 16, word data.
- addr, out, 32, word byte address.
- busy, out, 1, state is RUN or FLUSH.
- done, out, 1, state is DONE.
- wr_offset, out, 24, next word offset to be assigned.
- wrap_cnt, out, 16, ring wraps since start; saturating.
- ovf_cnt, out, 16, samples dropped because the holding FIFO was full; saturating.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, holding FIFO empty, write_en=0, data=0, addr=0, busy=0, done=0, wr_offset=0, wrap_cnt=0, ovf_cnt=0.
  - Reset mid-capture discards held words with no flush.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE/DONE + start, with rounded len ≥ BURST_LEN → RUN. Latch cfg; clear wr_offset, wrap_cnt, ovf_cnt.
  - start with rounded len < BURST_LEN is ignored. start in RUN or FLUSH is ignored.
  - RUN + stop → FLUSH if wr_offset % BURST_LEN ≠ 0, otherwise DRAIN condition: go to DONE once the holding FIFO is empty.
  - RUN, oneshot, wr_offset reaches len → stop accepting samples; DONE once the FIFO is empty.
  - FLUSH: push one PAD_WORD entry per cycle while the FIFO is not full, advancing wr_offset. When aligned and the FIFO is empty → DONE.
  - stop in IDLE, DONE, or FLUSH is ignored.
- Accept, RUN only: s_valid and FIFO not full → push {s_data, cfg_base_addr + wr_offset*ADDR_STEP}, then wr_offset+1.
  - If wr_offset+1 == len: continuous mode wraps wr_offset to 0 and increments wrap_cnt (saturating at FFFF); oneshot holds at len.
  - s_valid with FIFO full → word dropped, wr_offset unchanged, ovf_cnt+1 (saturating).
  - s_valid in FLUSH, DONE, or IDLE → ignored, not counted as overflow.
- Simultaneous stop + s_valid: the sample is accepted first, and alignment is evaluated on the updated offset.
- Address arithmetic is 32-bit modulo; no overflow checking.
- Output handshake: write_en = FIFO non-empty & dev_idle (combinational). data/addr always show the FIFO head (0 when empty). The FIFO pops on write_en.
  - Zero latency from dev_idle to write_en.
  - Push and pop may happen in the same cycle, including when the FIFO is full.
- Latency: a sample arriving in cycle t with an empty FIFO and dev_idle=1 appears on write_en in cycle t+1.

Optional Feature:
- Macro ADC_TEST_PATTERN_EN.
- When defined: extra input port test_mode (1 bit). In RUN with test_mode=1, the accepted data is a 16-bit counter that starts at 0 on each start and increments per accepted word, replacing s_data. Addresses, flow and padding are unchanged.
- When undefined: no test_mode port; data always comes from s_data.

Test Plan:
- Continuous, base=0x0010_0000, len=32, dev_idle=1, 16 samples 0x1000..0x100F → 16 write_en pulses, addr 0x100000..0x10001E in steps of 2, data matching, wr_offset=16.
- Continuous, len=32, 40 samples → write 33 goes to addr 0x100000, wrap_cnt=1, wr_offset=8.
- Oneshot, len=20 (rounds to 16), 20 samples → exactly 16 writes, extra samples ignored, ovf_cnt=0, done=1.
- 11 samples then stop → 5 writes of data 0x0000 at offsets 11..15, then done=1 with wr_offset=16.
- dev_idle=0 while 6 samples arrive (HOLD_DEPTH=4) → ovf_cnt=2. After dev_idle=1, 4 writes at offsets 0..3.
- reset_n=0 for one cycle mid-RUN with 3 words held → next cycle write_en=0, all outputs at reset values, state IDLE.
